loop_counter_2d: RTL and testbench

- Parametrised two-level loop counter; successor to the fixed 7-bit ripple counter.
- Generates inner/outer indices for the Binary-MLP datapath, e.g. register-file write address (inner) and neuron/layer index (outer).
- Adds start/stop control, run-time inner and outer bounds latched at start, enable-gated advance, and one-shot or continuous mode.
- Signals per-row completion (inner_fin) and whole-sweep completion (done).

---
 rtl/loop_counter_2d.sv | 108 ++++++++++
 tb/tb_loop_counter_2d.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/loop_counter_2d.sv
// Two-level inner/outer index generator with start/stop control. The bounds are
// captured when a sweep starts. A sweep either ends in a single DONE cycle or restarts by itself.
module loop_counter_2d #(
    parameter int CW_I       = 7,
    parameter int CW_O       = 7,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            stop,
    input  logic            en,
    input  logic [CW_I-1:0] inner_end,
    input  logic [CW_O-1:0] outer_end,
    output logic            busy,
    output logic [CW_I-1:0] inner_cnt,
    output logic [CW_O-1:0] outer_cnt,
    output logic            inner_fin,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW_I-1:0] inner_nxt, inner_end_q, inner_end_d;
    logic [CW_O-1:0] outer_nxt, outer_end_q, outer_end_d;
    logic            done_nxt;
    logic            last_inner, last_sweep;

    // Compare against the bound before incrementing, so all-ones bounds never wrap.
    assign last_inner = (inner_cnt == inner_end_q);
    assign last_sweep = last_inner && (outer_cnt == outer_end_q);
    assign busy       = (state_q != IDLE);
    assign inner_fin  = (state_q == RUN) && en && last_inner;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            inner_cnt   <= '0;
            outer_cnt   <= '0;
            inner_end_q <= '0;
            outer_end_q <= '0;
            done        <= 1'b0;
        end else begin
            state_q     <= state_d;
            inner_cnt   <= inner_nxt;
            outer_cnt   <= outer_nxt;
            inner_end_q <= inner_end_d;
            outer_end_q <= outer_end_d;
            done        <= done_nxt;
        end
    end

    always_comb begin
        state_d     = state_q;
        inner_nxt   = inner_cnt;
        outer_nxt   = outer_cnt;
        inner_end_d = inner_end_q;
        outer_end_d = outer_end_q;
        done_nxt    = 1'b0;
        case (state_q)
            IDLE: begin
                inner_nxt = '0;
                outer_nxt = '0;
                if (start && !stop) begin
                    state_d     = RUN;
                    inner_end_d = inner_end;
                    outer_end_d = outer_end;
                end
            end
            RUN: begin
                // stop takes precedence over the final advance, so an aborted sweep never reports done
                if (stop) begin
                    state_d   = IDLE;
                    inner_nxt = '0;
                    outer_nxt = '0;
                end else if (en) begin
                    if (last_sweep) begin
                        inner_nxt = '0;
                        outer_nxt = '0;
                        done_nxt  = 1'b1;
                        state_d   = CONTINUOUS ? RUN : DONE;
                    end else if (last_inner) begin
                        inner_nxt = '0;
                        outer_nxt = outer_cnt + CW_O'(1);
                    end else begin
                        inner_nxt = inner_cnt + CW_I'(1);
                    end
                end
            end
            DONE: begin
                state_d   = IDLE;
                inner_nxt = '0;
                outer_nxt = '0;
            end
            default: begin
                state_d   = IDLE;
                inner_nxt = '0;
                outer_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_loop_counter_2d.sv
// Bench for loop_counter_2d: one-shot and continuous instances share their inputs.
// Each instance is compared with an arithmetic reference model that counts advances.
module tb_loop_counter_2d;

    localparam int CW_I = 7;
    localparam int CW_O = 7;

    logic            clk = 1'b0;
    logic            rst, start, stop, en;
    logic [CW_I-1:0] inner_end;
    logic [CW_O-1:0] outer_end;

    logic            busy_os, fin_os, done_os;
    logic [CW_I-1:0] inner_os;
    logic [CW_O-1:0] outer_os;
    logic            busy_ct, fin_ct, done_ct;
    logic [CW_I-1:0] inner_ct;
    logic [CW_O-1:0] outer_ct;

    always #5 clk = ~clk;

    loop_counter_2d #(.CW_I(CW_I), .CW_O(CW_O), .CONTINUOUS(1'b0)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en),
        .inner_end(inner_end), .outer_end(outer_end),
        .busy(busy_os), .inner_cnt(inner_os), .outer_cnt(outer_os),
        .inner_fin(fin_os), .done(done_os)
    );

    loop_counter_2d #(.CW_I(CW_I), .CW_O(CW_O), .CONTINUOUS(1'b1)) dut_ct (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .en(en),
        .inner_end(inner_end), .outer_end(outer_end),
        .busy(busy_ct), .inner_cnt(inner_ct), .outer_cnt(outer_ct),
        .inner_fin(fin_ct), .done(done_ct)
    );

    // Model: phase 0/1/2 = idle/run/done, k = advances so far in the current sweep
    typedef struct {
        int phase;
        int k;
        int ie;
        int oe;
        bit dn;
    } model_t;

    typedef struct {
        bit rst, start, stop, en;
        int ie, oe;
        bit busy;
        int inner, outer;
        bit fin, dn;
    } vec_t;

    model_t m_os, m_ct;
    vec_t   tbl[$];
    int     vectors = 0;
    int     miscompares = 0;

    function automatic model_t modelStep(model_t m, bit cont, bit r, bit s, bit p, bit e, int ie, int oe);
        model_t n = m;
        n.dn = 1'b0;
        if (r) begin
            n.phase = 0; n.k = 0; n.ie = 0; n.oe = 0;
            return n;
        end
        case (m.phase)
            0: if (s && !p) begin
                n.phase = 1; n.k = 0; n.ie = ie; n.oe = oe;
            end
            1: if (p) begin
                n.phase = 0; n.k = 0;
            end else if (e) begin
                n.k = m.k + 1;
                if (n.k == (m.ie + 1) * (m.oe + 1)) begin
                    n.k  = 0;
                    n.dn = 1'b1;
                    if (!cont) n.phase = 2;
                end
            end
            default: begin
                n.phase = 0; n.k = 0;
            end
        endcase
        return n;
    endfunction

    function automatic vec_t mkVec(bit r, bit s, bit p, bit e, int ie, int oe,
                                   bit b, int ic, int oc, bit f, bit d);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.en = e; v.ie = ie; v.oe = oe;
        v.busy = b; v.inner = ic; v.outer = oc; v.fin = f; v.dn = d;
        return v;
    endfunction

    task automatic checkField(string name, logic [31:0] actual, logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkOutput(string tag, model_t m, logic b, logic [CW_I-1:0] ic,
                               logic [CW_O-1:0] oc, logic f, logic d);
        int ei, eo;
        ei = m.k % (m.ie + 1);
        eo = m.k / (m.ie + 1);
        checkField({tag, " busy"},  32'(b),  (m.phase != 0) ? 32'd1 : 32'd0);
        checkField({tag, " inner"}, 32'(ic), ei);
        checkField({tag, " outer"}, 32'(oc), eo);
        checkField({tag, " fin"},   32'(f),  (m.phase == 1 && en === 1'b1 && ei == m.ie) ? 32'd1 : 32'd0);
        checkField({tag, " done"},  32'(d),  32'(m.dn));
    endtask

    task automatic applyStimulus(bit r, bit s, bit p, bit e, int ie, int oe);
        @(negedge clk);
        rst = r; start = s; stop = p; en = e;
        inner_end = ie[CW_I-1:0];
        outer_end = oe[CW_O-1:0];
        #1;
    endtask

    task automatic stepModels();
        @(posedge clk);
        m_os = modelStep(m_os, 1'b0, rst, start, stop, en, int'(inner_end), int'(outer_end));
        m_ct = modelStep(m_ct, 1'b1, rst, start, stop, en, int'(inner_end), int'(outer_end));
    endtask

    task automatic checkBoth(string tag);
        checkOutput({tag, " os"}, m_os, busy_os, inner_os, outer_os, fin_os, done_os);
        checkOutput({tag, " ct"}, m_ct, busy_ct, inner_ct, outer_ct, fin_ct, done_ct);
    endtask

    task automatic tick(string tag, bit r, bit s, bit p, bit e, int ie, int oe);
        applyStimulus(r, s, p, e, ie, oe);
        checkBoth(tag);
        stepModels();
    endtask

    // Runs one sweep from IDLE; counts edges from the start edge until done is seen
    task automatic runSweep(string tag, int ie, int oe, bit toggle, int exp_edges);
        int  edges, fins;
        bit  seen, e;
        edges = 0; fins = 0; seen = 1'b0;
        tick({tag, " idle"}, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        tick({tag, " start"}, 1'b0, 1'b1, 1'b0, 1'b0, ie, oe);
        for (int t = 0; t < 40000 && !seen; t++) begin
            e = toggle ? (t % 2 == 0) : 1'b1;
            applyStimulus(1'b0, 1'b0, 1'b0, e, ie, oe);
            checkBoth(tag);
            if (fin_os === 1'b1) fins++;
            if (done_os === 1'b1) begin
                seen  = 1'b1;
                edges = t + 1;
            end
            stepModels();
        end
        if (!seen) begin
            miscompares++;
            $display("[TB] FAIL %s timeout: done never seen within 40000 cycles", tag);
        end
        checkField({tag, " edges"}, edges, exp_edges);
        checkField({tag, " fins"}, fins, oe + 1);
        tick({tag, " after"}, 1'b0, 1'b0, 1'b0, 1'b0, ie, oe);
        checkField({tag, " busy after"}, 32'(busy_os), 32'd0);
    endtask

    initial begin
        int dones;
        bit r, s, p, e;
        int ie, oe;

        rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b0;
        inner_end = '0; outer_end = '0;
        m_os = modelStep(m_os, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        m_ct = modelStep(m_ct, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);
        repeat (2) @(posedge clk);
        tick("reset", 1'b1, 1'b0, 1'b0, 1'b0, 0, 0);

        // Directed one-shot table: inputs this cycle, outputs seen during this cycle
        tbl.push_back(mkVec(0,1,0,0, 1,1, 0,0,0,0,0));
        tbl.push_back(mkVec(0,0,0,1, 1,1, 1,0,0,0,0));
        tbl.push_back(mkVec(0,0,0,0, 1,1, 1,1,0,0,0));
        tbl.push_back(mkVec(0,1,0,1, 0,0, 1,1,0,1,0));
        tbl.push_back(mkVec(0,0,0,1, 0,0, 1,0,1,0,0));
        tbl.push_back(mkVec(0,0,0,1, 0,0, 1,1,1,1,0));
        tbl.push_back(mkVec(0,1,0,1, 1,1, 1,0,0,0,1));
        tbl.push_back(mkVec(0,0,0,0, 1,1, 0,0,0,0,0));
        tbl.push_back(mkVec(0,1,1,0, 1,1, 0,0,0,0,0));
        tbl.push_back(mkVec(0,0,0,0, 1,1, 0,0,0,0,0));
        tbl.push_back(mkVec(0,1,0,0, 0,0, 0,0,0,0,0));
        tbl.push_back(mkVec(0,0,1,1, 0,0, 1,0,0,1,0));
        tbl.push_back(mkVec(0,0,0,0, 0,0, 0,0,0,0,0));
        tbl.push_back(mkVec(0,1,0,0, 0,0, 0,0,0,0,0));
        tbl.push_back(mkVec(0,0,0,1, 0,0, 1,0,0,1,0));
        tbl.push_back(mkVec(0,0,1,0, 0,0, 1,0,0,0,1));
        tbl.push_back(mkVec(0,0,0,0, 0,0, 0,0,0,0,0));
        for (int i = 0; i < tbl.size(); i++) begin
            applyStimulus(tbl[i].rst, tbl[i].start, tbl[i].stop, tbl[i].en, tbl[i].ie, tbl[i].oe);
            checkField($sformatf("tbl[%0d] busy", i),  32'(busy_os),  32'(tbl[i].busy));
            checkField($sformatf("tbl[%0d] inner", i), 32'(inner_os), tbl[i].inner);
            checkField($sformatf("tbl[%0d] outer", i), 32'(outer_os), tbl[i].outer);
            checkField($sformatf("tbl[%0d] fin", i),   32'(fin_os),   32'(tbl[i].fin));
            checkField($sformatf("tbl[%0d] done", i),  32'(done_os),  32'(tbl[i].dn));
            checkOutput("tbl ct", m_ct, busy_ct, inner_ct, outer_ct, fin_ct, done_ct);
            stepModels();
        end

        runSweep("sweep59x0", 59, 0, 1'b0, 61);
        runSweep("sweep3x2tog", 3, 2, 1'b1, 24);
        runSweep("sweep0x0", 0, 0, 1'b0, 2);

        // Continuous pattern (0,0)(1,0)(0,1)(1,1) repeating, then stop mid-sequence
        tick("ct idle", 1'b0, 1'b0, 1'b1, 1'b0, 0, 0);
        tick("ct start", 1'b0, 1'b1, 1'b0, 1'b0, 1, 1);
        dones = 0;
        for (int t = 0; t < 14; t++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1, 1);
            checkField("ct seq inner", 32'(inner_ct), t % 2);
            checkField("ct seq outer", 32'(outer_ct), (t / 2) % 2);
            if (done_ct === 1'b1) dones++;
            checkBoth("ct seq");
            stepModels();
        end
        checkField("ct done count", dones, 3);
        tick("ct stop", 1'b0, 1'b0, 1'b1, 1'b1, 1, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1, 1);
        checkField("ct stopped busy", 32'(busy_ct), 32'd0);
        checkField("ct stopped inner", 32'(inner_ct), 32'd0);
        checkField("ct stopped done", 32'(done_ct), 32'd0);
        checkBoth("ct stopped");
        stepModels();

        // Reset in the middle of a sweep at inner index 40
        tick("mrst start", 1'b0, 1'b1, 1'b0, 1'b0, 59, 0);
        for (int t = 0; t < 100 && (m_os.k % (m_os.ie + 1)) != 40; t++)
            tick("mrst run", 1'b0, 1'b0, 1'b0, 1'b1, 59, 0);
        checkField("mrst reached 40", m_os.k, 40);
        tick("mrst pulse", 1'b1, 1'b0, 1'b0, 1'b1, 59, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 59, 0);
        checkField("mrst busy", 32'(busy_os), 32'd0);
        checkField("mrst inner", 32'(inner_os), 32'd0);
        checkField("mrst done", 32'(done_os), 32'd0);
        checkBoth("mrst after");
        stepModels();

        // Bound change while running is ignored until the next start
        tick("bound start", 1'b0, 1'b1, 1'b0, 1'b0, 50, 0);
        for (int t = 0; t < 60; t++)
            tick("bound run", 1'b0, 1'b0, 1'b0, 1'b1, 83, 0);
        runSweep("sweep83x0", 83, 0, 1'b0, 85);

        runSweep("sweep127x127", 127, 127, 1'b0, 16385);

        // Randomised traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            s  = ($urandom_range(0, 7) == 0);
            p  = ($urandom_range(0, 39) == 0);
            e  = ($urandom_range(0, 3) != 0);
            ie = ($urandom_range(0, 19) == 0) ? 127 : int'($urandom_range(0, 6));
            oe = int'($urandom_range(0, 4));
            tick("rand", r, s, p, e, ie, oe);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
